// File: rtl/ifu_icache_ctrl.sv
// ifu_icache_ctrl: control FSM for the 2-way, 512-set IFU instruction cache.
// Sequences tag/data lookups, issues one refill request per miss, writes the
// two 128-bit refill beats into the victim way, then writes the tag.
// Keeps a 1-bit-per-set LRU (bit = way to evict next).
// Optional build macro: ICACHE_FLUSH_EN (adds flush_req/flush_busy and FLUSH).
module ifu_icache_ctrl #(
  parameter int SETS   = 512,
  parameter int TAG_W  = 18,
  parameter int BEAT_W = 128,
  localparam int IDX_W = $clog2(SETS),
  localparam int LA_W  = TAG_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ICACHE_FLUSH_EN
  input  logic              flush_req,
  output logic              flush_busy,
`endif
  input  logic              ifu_req_vld,
  input  logic [LA_W-1:0]   ifu_req_addr,
  output logic              ifu_req_rdy,
  output logic              ifu_rsp_vld,
  output logic              ifu_rsp_way,
  output logic              ifu_rsp_miss,
  output logic              arr_rd_en,
  output logic [IDX_W-1:0]  arr_rd_idx,
  input  logic              tag_hit_way0,
  input  logic              tag_hit_way1,
  output logic              refill_req_vld,
  output logic [LA_W-1:0]   refill_req_addr,
  input  logic              refill_req_rdy,
  input  logic              refill_data_vld,
  input  logic [BEAT_W-1:0] refill_data,
  output logic              arr_wr_en,
  output logic              arr_wr_way,
  output logic              arr_wr_bank,
  output logic [IDX_W-1:0]  arr_wr_idx,
  output logic [BEAT_W-1:0] arr_wr_data,
  output logic              tag_wr_en,
  output logic [1:0]        tag_wr_way_mask,
  output logic [TAG_W-1:0]  tag_wr_tag,
  output logic              tag_wr_vld
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MISS_REQ = 3'd2;
  localparam logic [2:0] S_REFILL_0 = 3'd3;
  localparam logic [2:0] S_REFILL_1 = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
`ifdef ICACHE_FLUSH_EN
  localparam logic [2:0] S_FLUSH    = 3'd6;
`endif

  logic [2:0]       state_q, state_d;
  logic [LA_W-1:0]  req_addr_q, req_addr_d;
  logic             victim_q, victim_d;
  logic [SETS-1:0]  lru_q;
  logic             lru_we, lru_bit;
  logic             hit, hit_way, accept, flush_pend;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign idx     = req_addr_q[IDX_W-1:0];
  assign tag     = req_addr_q[LA_W-1:IDX_W];
  assign hit     = tag_hit_way0 | tag_hit_way1;
  // way0 wins if both ways claim the line
  assign hit_way = ~tag_hit_way0;

`ifdef ICACHE_FLUSH_EN
  logic             flush_pend_q;
  logic [IDX_W-1:0] cnt_q;
  // a flush request seen this cycle already counts as pending
  assign flush_pend = flush_pend_q | flush_req;

  // flush pending latch and the set counter walked during FLUSH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      flush_pend_q <= flush_pend && (state_q != S_IDLE);
      cnt_q        <= (state_q == S_FLUSH) ? cnt_q + 1'b1 : '0;
    end
  end
`else
  assign flush_pend = 1'b0;
`endif

  // new requests are taken from IDLE, or back-to-back behind a LOOKUP hit
  assign ifu_req_rdy = !rst && !flush_pend &&
                       ((state_q == S_IDLE) || ((state_q == S_LOOKUP) && hit));
  assign accept      = ifu_req_vld & ifu_req_rdy;
  assign arr_rd_en   = accept;
  assign arr_rd_idx  = accept ? ifu_req_addr[IDX_W-1:0] : '0;

  // next-state and output decode
  always_comb begin
    state_d         = state_q;
    req_addr_d      = req_addr_q;
    victim_d        = victim_q;
    lru_we          = 1'b0;
    lru_bit         = 1'b0;
    ifu_rsp_vld     = 1'b0;
    ifu_rsp_way     = 1'b0;
    ifu_rsp_miss    = 1'b0;
    refill_req_vld  = 1'b0;
    refill_req_addr = '0;
    arr_wr_en       = 1'b0;
    arr_wr_way      = 1'b0;
    arr_wr_bank     = 1'b0;
    arr_wr_idx      = '0;
    arr_wr_data     = '0;
    tag_wr_en       = 1'b0;
    tag_wr_way_mask = 2'b00;
    tag_wr_tag      = '0;
    tag_wr_vld      = 1'b0;
`ifdef ICACHE_FLUSH_EN
    flush_busy      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef ICACHE_FLUSH_EN
        if (flush_pend) state_d = S_FLUSH;
        else
`endif
        if (accept) begin
          req_addr_d = ifu_req_addr;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          ifu_rsp_vld = 1'b1;
          ifu_rsp_way = hit_way;
          lru_we      = 1'b1;
          lru_bit     = ~hit_way;
          if (accept) req_addr_d = ifu_req_addr;
          else        state_d    = S_IDLE;
        end else begin
          victim_d = lru_q[idx];
          state_d  = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        refill_req_vld  = 1'b1;
        refill_req_addr = req_addr_q;
        if (refill_req_rdy) state_d = S_REFILL_0;
      end
      S_REFILL_0, S_REFILL_1: begin
        if (refill_data_vld) begin
          arr_wr_en   = 1'b1;
          arr_wr_way  = victim_q;
          arr_wr_bank = (state_q == S_REFILL_1);
          arr_wr_idx  = idx;
          arr_wr_data = refill_data;
          if (state_q == S_REFILL_1) begin
            // tag goes in with the last beat so a partial line is never valid
            tag_wr_en       = 1'b1;
            tag_wr_way_mask = victim_q ? 2'b10 : 2'b01;
            tag_wr_tag      = tag;
            tag_wr_vld      = 1'b1;
            state_d         = S_DONE;
          end else begin
            state_d = S_REFILL_1;
          end
        end
      end
      S_DONE: begin
        ifu_rsp_vld  = 1'b1;
        ifu_rsp_way  = victim_q;
        ifu_rsp_miss = 1'b1;
        lru_we       = 1'b1;
        lru_bit      = ~victim_q;
        state_d      = S_IDLE;
      end
`ifdef ICACHE_FLUSH_EN
      S_FLUSH: begin
        flush_busy      = 1'b1;
        tag_wr_en       = 1'b1;
        tag_wr_way_mask = 2'b11;
        arr_wr_idx      = cnt_q;
        if (cnt_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // state, captured request, victim way and LRU bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      victim_q   <= 1'b0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      victim_q   <= victim_d;
`ifdef ICACHE_FLUSH_EN
      if (state_q == S_FLUSH) lru_q <= '0;
      else
`endif
      if (lru_we) lru_q[idx] <= lru_bit;
    end
  end

`ifndef SYNTHESIS
  // both ways matching the same line means the tag array is corrupt
  a_one_hot_hit: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_LOOKUP) |-> !(tag_hit_way0 && tag_hit_way1));
`endif

endmodule

// File: tb/tb_ifu_icache_ctrl.sv
// Scoreboard bench for ifu_icache_ctrl: stimulus pushes expected responses,
// data writes, tag writes and refill requests; a negedge monitor pops and
// compares each one as the DUT presents it. A small tag-array model answers
// lookups one cycle after arr_rd_en.
module tb_ifu_icache_ctrl;
  logic clk = 1'b0;
  logic rst;
`ifdef ICACHE_FLUSH_EN
  logic flush_req, flush_busy;
  int   busy_cnt = 0;
`endif
  logic         ifu_req_vld, ifu_req_rdy, ifu_rsp_vld, ifu_rsp_way, ifu_rsp_miss;
  logic [26:0]  ifu_req_addr, refill_req_addr;
  logic         arr_rd_en, tag_hit_way0, tag_hit_way1;
  logic [8:0]   arr_rd_idx, arr_wr_idx;
  logic         refill_req_vld, refill_req_rdy, refill_data_vld;
  logic [127:0] refill_data, arr_wr_data;
  logic         arr_wr_en, arr_wr_way, arr_wr_bank;
  logic         tag_wr_en, tag_wr_vld;
  logic [1:0]   tag_wr_way_mask;
  logic [17:0]  tag_wr_tag;

  always #5 clk = ~clk;

  ifu_icache_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef ICACHE_FLUSH_EN
    .flush_req(flush_req), .flush_busy(flush_busy),
`endif
    .ifu_req_vld(ifu_req_vld), .ifu_req_addr(ifu_req_addr), .ifu_req_rdy(ifu_req_rdy),
    .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_way(ifu_rsp_way), .ifu_rsp_miss(ifu_rsp_miss),
    .arr_rd_en(arr_rd_en), .arr_rd_idx(arr_rd_idx),
    .tag_hit_way0(tag_hit_way0), .tag_hit_way1(tag_hit_way1),
    .refill_req_vld(refill_req_vld), .refill_req_addr(refill_req_addr),
    .refill_req_rdy(refill_req_rdy), .refill_data_vld(refill_data_vld),
    .refill_data(refill_data),
    .arr_wr_en(arr_wr_en), .arr_wr_way(arr_wr_way), .arr_wr_bank(arr_wr_bank),
    .arr_wr_idx(arr_wr_idx), .arr_wr_data(arr_wr_data),
    .tag_wr_en(tag_wr_en), .tag_wr_way_mask(tag_wr_way_mask),
    .tag_wr_tag(tag_wr_tag), .tag_wr_vld(tag_wr_vld)
  );

  typedef struct packed {logic way; logic miss;} rsp_t;
  typedef struct packed {logic way; logic bank; logic [8:0] idx; logic [127:0] data;} dw_t;
  typedef struct packed {logic [1:0] mask; logic [17:0] tag; logic vld; logic [8:0] idx;} tw_t;

  rsp_t        rsp_q[$];
  dw_t         dw_q[$];
  tw_t         tw_q[$];
  logic [26:0] rf_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, last_rsp = -10, run_len = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // tag array model: answers a read one cycle later, absorbs tag writes
  logic [17:0] mtag[2][512];
  logic        mval[2][512];
  initial for (int w = 0; w < 2; w++) for (int s = 0; s < 512; s++) mval[w][s] = 1'b0;
  always @(posedge clk) begin : tagmem
    logic h0, h1;
    h0 = 1'b0; h1 = 1'b0;
    if (arr_rd_en) begin
      h0 = mval[0][arr_rd_idx] && (mtag[0][arr_rd_idx] == ifu_req_addr[26:9]);
      h1 = mval[1][arr_rd_idx] && (mtag[1][arr_rd_idx] == ifu_req_addr[26:9]);
    end
    if (tag_wr_en)
      for (int w = 0; w < 2; w++)
        if (tag_wr_way_mask[w]) begin
          mval[w][arr_wr_idx] = tag_wr_vld;
          mtag[w][arr_wr_idx] = tag_wr_tag;
        end
    #1;
    tag_hit_way0 = h0;
    tag_hit_way1 = h1;
  end

  // monitor: every presented output must match the head of its queue
  always @(negedge clk) begin
    if (ifu_rsp_vld) begin
      run_len  = (last_rsp == cyc - 1) ? run_len + 1 : 1;
      last_rsp = cyc;
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else chk("rsp", {ifu_rsp_way, ifu_rsp_miss}, rsp_q.pop_front());
    end
    if (arr_wr_en) begin
      if (dw_q.size() == 0) chk("data_wr_unexpected", 1, 0);
      else chk("data_wr", {arr_wr_way, arr_wr_bank, arr_wr_idx, arr_wr_data}, dw_q.pop_front());
    end
    if (tag_wr_en) begin
      if (tw_q.size() == 0) chk("tag_wr_unexpected", 1, 0);
      else chk("tag_wr", {tag_wr_way_mask, tag_wr_tag, tag_wr_vld, arr_wr_idx}, tw_q.pop_front());
    end
    if (refill_req_vld && refill_req_rdy) begin
      if (rf_q.size() == 0) chk("refill_req_unexpected", 1, 0);
      else chk("refill_req", refill_req_addr, rf_q.pop_front());
    end
`ifdef ICACHE_FLUSH_EN
    if (flush_busy) busy_cnt++;
`endif
  end

  // all stimulus tasks start and end at posedge+2
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [26:0] a, output int waits);
    ifu_req_vld = 1'b1; ifu_req_addr = a; waits = 0;
    @(negedge clk);
    while (!ifu_req_rdy && waits < 200) begin waits++; @(negedge clk); end
    if (waits >= 200) chk("req_timeout", 0, 1);
    @(posedge clk); #2;
    ifu_req_vld = 1'b0;
  endtask

  // hold refill_req_rdy low for 'stall' request cycles, checking stability
  task automatic grant(input int stall, input logic [26:0] a);
    int k = 0;
    refill_req_rdy = 1'b0;
    @(negedge clk);
    while (!refill_req_vld && k < 100) begin k++; @(negedge clk); end
    if (k >= 100) chk("refill_req_timeout", 0, 1);
    for (int i = 0; i < stall; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_vld", refill_req_vld, 1);
      chk("stall_addr", refill_req_addr, a);
    end
    @(posedge clk); #2; refill_req_rdy = 1'b1;
    @(posedge clk); #2; refill_req_rdy = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d, input int gap);
    idle(gap);
    refill_data_vld = 1'b1; refill_data = d;
    @(posedge clk); #2;
    refill_data_vld = 1'b0;
  endtask

  task automatic hit_txn(input logic [26:0] a, input logic way, output int waits);
    rsp_q.push_back('{way, 1'b0});
    send(a, waits);
  endtask

  task automatic miss_txn(input logic [26:0] a, input logic v, input int stall,
                          input int gap, input logic [127:0] d0, input logic [127:0] d1);
    int w;
    rf_q.push_back(a);
    dw_q.push_back('{v, 1'b0, a[8:0], d0});
    dw_q.push_back('{v, 1'b1, a[8:0], d1});
    tw_q.push_back('{(v ? 2'b10 : 2'b01), a[26:9], 1'b1, a[8:0]});
    rsp_q.push_back('{v, 1'b1});
    send(a, w);
    grant(stall, a);
    beat(d0, 0);
    beat(d1, gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, tot;
    rst = 1'b1; ifu_req_vld = 1'b1; ifu_req_addr = 27'h40;
    refill_req_rdy = 1'b0; refill_data_vld = 1'b0; refill_data = '0;
    tag_hit_way0 = 1'b0; tag_hit_way1 = 1'b0;
`ifdef ICACHE_FLUSH_EN
    flush_req = 1'b0;
`endif
    // reset state, with a request already offered
    @(negedge clk);
    chk("rst_rdy", ifu_req_rdy, 0);
    chk("rst_outs", {arr_rd_en, ifu_rsp_vld, refill_req_vld, arr_wr_en, tag_wr_en}, 0);
    @(posedge clk); #2; rst = 1'b0; ifu_req_vld = 1'b0;
    @(negedge clk);
    chk("idle_rdy", ifu_req_rdy, 1);
    @(posedge clk); #2;

    // cold miss: idx 0x40 tag 0 -> way0
    miss_txn(27'h0000040, 1'b0, 2, 0, 128'hA, 128'hB);
    idle(2);
    // hit on way0, then conflict miss (tag 1) evicts way1
    hit_txn(27'h0000040, 1'b0, w);
    idle(1);
    miss_txn(27'h0000240, 1'b1, 1, 0, 128'hC, 128'hD);
    idle(2);
    // four back-to-back hits
    tot = 0;
    hit_txn(27'h0000040, 1'b0, w); tot += w;
    hit_txn(27'h0000240, 1'b1, w); tot += w;
    hit_txn(27'h0000040, 1'b0, w); tot += w;
    hit_txn(27'h0000240, 1'b1, w); tot += w;
    chk("b2b_rdy_waits", tot, 0);
    idle(1);
    chk("b2b_rsp_run", run_len, 4);
    // stalled refill: 10 stall cycles, 3 idle cycles between beats
    miss_txn(27'h0000441, 1'b0, 10, 3, 128'hE, 128'hF);
    idle(2);

    // reset after beat0: no tag write, no response, stray beat ignored
    rf_q.push_back(27'h0000640);
    dw_q.push_back('{1'b0, 1'b0, 9'h040, 128'h1111});
    send(27'h0000640, w);
    grant(2, 27'h0000640);
    beat(128'h1111, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", ifu_req_rdy, 0);
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_rdy", ifu_req_rdy, 1);
    @(posedge clk); #2;
    beat(128'hDEAD, 0);
    idle(2);
    // LRU[0x41] was 1 before reset; cleared LRU picks way0
    miss_txn(27'h0000A41, 1'b0, 1, 0, 128'h2222, 128'h3333);
    idle(2);

`ifdef ICACHE_FLUSH_EN
    // flush requested between refill beats runs after DONE
    rf_q.push_back(27'h0000C42);
    dw_q.push_back('{1'b0, 1'b0, 9'h042, 128'h44});
    dw_q.push_back('{1'b0, 1'b1, 9'h042, 128'h55});
    tw_q.push_back('{2'b01, 18'h6, 1'b1, 9'h042});
    rsp_q.push_back('{1'b0, 1'b1});
    for (int i = 0; i < 512; i++) tw_q.push_back('{2'b11, 18'h0, 1'b0, 9'(i)});
    busy_cnt = 0;
    send(27'h0000C42, w);
    grant(1, 27'h0000C42);
    beat(128'h44, 0);
    flush_req = 1'b1; idle(1); flush_req = 1'b0;
    beat(128'h55, 0);
    idle(530);
    chk("flush_busy_cycles", busy_cnt, 512);
    @(negedge clk);
    chk("post_flush_rdy", ifu_req_rdy, 1);
    @(posedge clk); #2;
`endif

    idle(3);
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("dw_q_empty", dw_q.size(), 0);
    chk("tw_q_empty", tw_q.size(), 0);
    chk("rf_q_empty", rf_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifu_icache_ctrl.md
Name: ifu_icache_ctrl

Overview:
- Control FSM for the 32KB, 2-way, 512-set IFU instruction cache.
- Each cacheline is 2 x 128-bit banks, and each way/bank is a separate data array.
- Sequences tag/data lookups and handles misses: one refill request, two 128-bit beats, then the tag write.
- Keeps a 1-bit-per-set LRU and drives the data-array and tag-array write ports.
- Sits between the IFU fetch stage, the tag/data SRAMs and the refill bus.

Parameters:
- SETS, 512, number of sets; index width = log2(SETS) = 9.
- TAG_W, 18, tag width; addr[31:14].
- BEAT_W, 128, refill beat width and data bank width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ifu_req_vld  in  1  fetch lookup request
- ifu_req_addr  in  27  line address [31:5]; index = [13:5], tag = [31:14]
- ifu_req_rdy  out  1  request accepted when vld & rdy
- ifu_rsp_vld  out  1  lookup complete (one-cycle pulse)
- ifu_rsp_way  out  1  way holding the line
- ifu_rsp_miss  out  1  response came from a refill
- arr_rd_en  out  1  tag + data array read enable
- arr_rd_idx  out  9  read set index
- tag_hit_way0  in  1  valid & tag match on way0, one cycle after arr_rd_en
- tag_hit_way1  in  1  valid & tag match on way1, one cycle after arr_rd_en
- refill_req_vld  out  1  refill request
- refill_req_addr  out  27  refill line address
- refill_req_rdy  in  1  refill request accepted
- refill_data_vld  in  1  refill beat valid; beat0 = bank0, beat1 = bank1; no back-pressure
- refill_data  in  128  refill beat data
- arr_wr_en  out  1  data array write
- arr_wr_way  out  1  data write way
- arr_wr_bank  out  1  data write bank
- arr_wr_idx  out  9  write set index (data and tag)
- arr_wr_data  out  128  data write value
- tag_wr_en  out  1  tag array write
- tag_wr_way_mask  out  2  tag ways written
- tag_wr_tag  out  18  tag written
- tag_wr_vld  out  1  valid bit written

Behaviour:
- States: IDLE, LOOKUP, MISS_REQ, REFILL_B0, REFILL_B1, DONE, plus FLUSH when the optional feature is built.
- Reset: state = IDLE, LRU[511:0] = 0, all request/write/response outputs = 0. ifu_req_rdy = 0 while rst is high.
- Request capture, IDLE:
  - ifu_req_rdy = 1.
  - On vld & rdy: arr_rd_en = 1, arr_rd_idx = addr[13:5], addr registered into req_addr, go to LOOKUP.
- LOOKUP, hit:
  - hit = tag_hit_way0 | tag_hit_way1.
  - On hit: ifu_rsp_vld = 1, ifu_rsp_miss = 0, ifu_rsp_way = tag_hit_way0 ? 0 : 1. Both hits set → way0, simulation assertion fires.
  - LRU[idx] <= ~way.
  - ifu_req_rdy = 1 in this cycle, so a back-to-back request is accepted and issues its read the same cycle (state stays LOOKUP); otherwise go to IDLE.
  - Hit latency: 1 cycle after acceptance.
- LOOKUP, miss:
  - victim <= LRU[idx], go to MISS_REQ. ifu_req_rdy = 0.
- MISS_REQ:
  - refill_req_vld = 1, refill_req_addr = req_addr, held stable until refill_req_rdy.
  - On acceptance go to REFILL_B0.
- REFILL_B0 / REFILL_B1:
  - On refill_data_vld: arr_wr_en = 1, way = victim, bank = 0 or 1 respectively, idx = req_addr[13:5], data = refill_data, same cycle.
  - Beat0 moves to REFILL_B1.
  - Beat1 also asserts tag_wr_en = 1, tag_wr_way_mask = onehot(victim), tag_wr_tag = req_addr[31:14], tag_wr_vld = 1, and moves to DONE.
  - Idle cycles between beats are allowed.
- DONE:
  - ifu_rsp_vld = 1, ifu_rsp_miss = 1, ifu_rsp_way = victim.
  - LRU[idx] <= ~victim. Go to IDLE.
  - Miss latency: 3 cycles + bus latency.
- refill_data_vld outside REFILL_B0/B1 is ignored, including stale beats after a reset.
- Reset mid-refill: FSM returns to IDLE, no partial tag write is issued. Data may be partially written, which is harmless because the tag stays unwritten.
- All outputs are combinational decodes of registered state/req_addr/victim, except ifu_req_rdy and the LOOKUP hit response, which also depend on tag_hit_*.

Optional Feature:
- Macro: ICACHE_FLUSH_EN.
- When defined:
  - Adds ports flush_req in 1 and flush_busy out 1.
  - flush_req is latched as pending in any state and taken only from IDLE, with priority over ifu_req_vld; ifu_req_rdy = 0 while pending.
  - FLUSH lasts 512 cycles. A 9-bit counter runs 0→511 with tag_wr_en = 1, tag_wr_way_mask = 2'b11, tag_wr_vld = 0, arr_wr_idx = counter.
  - LRU is cleared. flush_busy = 1 throughout FLUSH. After counter = 511, go to IDLE.
- When undefined: no ports, no FLUSH state, no flush logic.

Test Plan:
- Cold miss:
  - Stimulus: req addr 0x0000040 (idx 0x040, tag 0), rdy after 2 cycles, beats A then B.
  - Response: refill_req_addr = 0x0000040; data writes way0 bank0 = A, then way0 bank1 = B; tag write way0 tag 0 vld 1; rsp_miss = 1, way 0; LRU[0x40] = 1.
- Hit then conflict:
  - Stimulus: re-request the same line with tag_hit_way0 = 1; then a different tag at idx 0x040 misses.
  - Response: first request gives 1-cycle rsp way0, miss 0. The conflict miss refills into victim way1.
- Back-to-back hits:
  - Stimulus: 4 consecutive requests, all hitting.
  - Response: ifu_req_rdy continuously 1, 4 rsp pulses in 4 consecutive cycles.
- Stalled refill:
  - Stimulus: refill_req_rdy held 0 for 10 cycles; 3 idle cycles between beats.
  - Response: req_vld/addr stable for all 10 cycles; exactly 2 data writes and 1 tag write.
- Reset mid-refill:
  - Stimulus: rst asserted after beat0, then a stray beat arrives.
  - Response: no tag write, stray beat ignored, rdy = 1 after reset deasserts, LRU = 0.
- ICACHE_FLUSH_EN:
  - Stimulus: flush_req during a refill.
  - Response: flush starts after DONE; 512 tag writes, idx 0..511, mask 11, vld 0; flush_busy high exactly 512 cycles.
